// File: rtl/debounced_accum_reg.sv
// Accumulator register updated once per debounced push-button press.
// Each press does one LOAD, ADD, SUB or CLEAR, and keeps a sticky carry/borrow flag.
//   state          | meaning
//   S_IDLE         | button released, waiting for a press
//   S_PRESS_WAIT   | press seen, counting stable-high cycles
//   S_FIRE         | one-cycle commit, register updates on the closing edge
//   S_HELD         | press accepted, waiting for a release
//   S_RELEASE_WAIT | release seen, counting stable-low cycles
module debounced_accum_reg #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             commit,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_FIRE,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_m;
  logic             btn_s;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // The extra top bit is the carry out of ADD and the borrow out of SUB.
  assign sum  = {1'b0, data_out} + {1'b0, data_in};
  assign diff = {1'b0, data_out} - {1'b0, data_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      data_out <= '0;
      carry    <= 1'b0;
      commit   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      commit <= 1'b0;
      busy   <= 1'b1;
      case (state)
        S_IDLE: begin
          if (btn_s) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_PRESS_WAIT: begin
          if (!btn_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= S_FIRE;
            commit <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIRE: begin
          state <= S_HELD;
          case (mode)
            2'b00: begin
              data_out <= data_in;
              carry    <= 1'b0;
            end
            2'b01: begin
              if (sum[WIDTH]) begin
                carry    <= 1'b1;
                data_out <= (SATURATE != 0) ? '1 : sum[WIDTH-1:0];
              end else begin
                data_out <= sum[WIDTH-1:0];
              end
            end
            2'b10: begin
              if (diff[WIDTH]) begin
                carry    <= 1'b1;
                data_out <= (SATURATE != 0) ? '0 : diff[WIDTH-1:0];
              end else begin
                data_out <= diff[WIDTH-1:0];
              end
            end
            default: begin
              data_out <= '0;
              carry    <= 1'b0;
            end
          endcase
        end
        S_HELD: begin
          if (!btn_s) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (btn_s) begin
            state <= S_HELD;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounced_accum_reg.sv
// Randomised bench for debounced_accum_reg: a wrapping and a saturating instance share stimulus
// and are compared every cycle against a run-length debounce model.
module tb_debounced_accum_reg;

  localparam int W    = 4;
  localparam int D    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn;
  logic [1:0]   mode;
  logic [W-1:0] din;
  logic [W-1:0] dout0, dout1;
  logic         cy0, cy1, com0, com1, busy0, busy1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_commit = 0;

  bit m_s1, m_s2, m_lvl, m_fire;
  int m_run;
  int m_acc[2];
  bit m_cy[2];

  debounced_accum_reg #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .btn(btn), .mode(mode), .data_in(din),
    .data_out(dout0), .carry(cy0), .commit(com0), .busy(busy0)
  );

  debounced_accum_reg #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .btn(btn), .mode(mode), .data_in(din),
    .data_out(dout1), .carry(cy1), .commit(com1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic void apply_op(input int i, input int op, input int d, input bit sat);
    int s;
    case (op)
      0: begin m_acc[i] = d; m_cy[i] = 1'b0; end
      1: begin
        s = m_acc[i] + d;
        if (s > MAXV) begin m_cy[i] = 1'b1; m_acc[i] = sat ? MAXV : s - (MAXV + 1); end
        else m_acc[i] = s;
      end
      2: begin
        if (d > m_acc[i]) begin m_cy[i] = 1'b1; m_acc[i] = sat ? 0 : m_acc[i] - d + MAXV + 1; end
        else m_acc[i] = m_acc[i] - d;
      end
      default: begin m_acc[i] = 0; m_cy[i] = 1'b0; end
    endcase
  endfunction

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_fire = 0; m_run = 0;
    m_acc[0] = 0; m_acc[1] = 0; m_cy[0] = 0; m_cy[1] = 0;
  endfunction

  // A level change is accepted after D+1 consecutive synchronised samples at the new level;
  // the sample at the edge closing the commit cycle is ignored.
  function automatic void model_edge();
    bit bs;
    bs = m_s2;
    if (m_fire) begin
      apply_op(0, int'(mode), int'(din), 1'b0);
      apply_op(1, int'(mode), int'(din), 1'b1);
      m_fire = 0;
    end else if (bs != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl  = ~m_lvl;
        m_run  = 0;
        m_fire = m_lvl;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endfunction

  task automatic compare_all();
    check_eq("wrap_data_out", 32'(dout0), 32'(m_acc[0]));
    check_eq("wrap_carry",    32'(cy0),   32'(m_cy[0]));
    check_eq("wrap_commit",   32'(com0),  32'(m_fire));
    check_eq("wrap_busy",     32'(busy0), 32'(m_lvl || m_fire || m_run > 0));
    check_eq("sat_data_out",  32'(dout1), 32'(m_acc[1]));
    check_eq("sat_carry",     32'(cy1),   32'(m_cy[1]));
    check_eq("sat_commit",    32'(com1),  32'(m_fire));
    check_eq("sat_busy",      32'(busy1), 32'(m_lvl || m_fire || m_run > 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (com0) n_commit++;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_eq("rst_data_out", 32'(dout0), 32'd0);
    check_eq("rst_carry",    32'(cy0),   32'd0);
    check_eq("rst_busy",     32'(busy0), 32'd0);
    compare_all();
    #1 reset = 1'b1;
  endtask

  task automatic press(input logic [1:0] op, input logic [W-1:0] d);
    mode = op; din = d; btn = 1'b1;
    repeat (12) step();
    btn = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    int first_a, rel_steps, c0;
    logic [W-1:0] held;
    reset = 1'b0; btn = 1'b0; mode = 2'b00; din = '0;
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;
    repeat (3) step();

    // load with latency measurement and release timing
    mode = 2'b00; din = 4'hA; btn = 1'b1;
    first_a = 0; c0 = n_commit;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (first_a == 0 && dout0 == 4'hA) first_a = i;
    end
    check_eq("load_latency", 32'(first_a), 32'd8);
    check_eq("load_one_commit", 32'(n_commit - c0), 32'd1);
    btn = 1'b0; rel_steps = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rel_steps == 0 && !busy0) rel_steps = i;
    end
    check_eq("release_latency", 32'(rel_steps), 32'd7);

    // short pulses and a release bounce
    held = dout0; c0 = n_commit;
    mode = 2'b11;
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1; repeat (w) step();
      btn = 1'b0; repeat (10) step();
    end
    check_eq("glitch_no_commit", 32'(n_commit - c0), 32'd0);
    check_eq("glitch_hold", 32'(dout0), 32'(held));
    mode = 2'b00; din = 4'h3; btn = 1'b1;
    repeat (12) step();
    btn = 1'b0; repeat (2) step();
    btn = 1'b1; repeat (2) step();
    btn = 1'b0; repeat (12) step();
    check_eq("bounce_one_commit", 32'(n_commit - c0), 32'd1);
    check_eq("bounce_value", 32'(dout0), 32'h3);

    // arithmetic, wrap vs saturate
    press(2'b00, 4'hC);
    press(2'b01, 4'h5);
    check_eq("add_wrap", 32'(dout0), 32'h1);
    check_eq("add_wrap_cy", 32'(cy0), 32'd1);
    check_eq("add_sat", 32'(dout1), 32'hF);
    check_eq("add_sat_cy", 32'(cy1), 32'd1);
    press(2'b01, 4'h2);
    check_eq("add_sticky", 32'(dout0), 32'h3);
    check_eq("add_sticky_cy", 32'(cy0), 32'd1);
    press(2'b11, 4'h7);
    check_eq("clear", 32'(dout0), 32'h0);
    check_eq("clear_cy", 32'(cy0), 32'd0);
    press(2'b00, 4'h2);
    press(2'b10, 4'h7);
    check_eq("sub_wrap", 32'(dout0), 32'hB);
    check_eq("sub_wrap_cy", 32'(cy0), 32'd1);
    check_eq("sub_sat", 32'(dout1), 32'h0);
    check_eq("sub_sat_cy", 32'(cy1), 32'd1);

    // reset during press debounce, then during the commit cycle
    press(2'b00, 4'h5);
    mode = 2'b00; din = 4'h9; btn = 1'b1;
    repeat (4) step();
    async_reset();
    btn = 1'b0; repeat (12) step();
    check_eq("pw_abort_value", 32'(dout0), 32'h0);
    press(2'b00, 4'h5);
    mode = 2'b00; din = 4'h9; btn = 1'b1;
    repeat (7) step();
    check_eq("fire_reached", 32'(com0), 32'd1);
    async_reset();
    c0 = n_commit;
    repeat (6) step();
    check_eq("reheld_no_early_fire", 32'(n_commit - c0), 32'd0);
    repeat (6) step();
    btn = 1'b0; repeat (12) step();
    check_eq("repress_value", 32'(dout0), 32'h9);

    // operand churn while held: only the commit-cycle values count
    c0 = n_commit; btn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      mode = 2'($urandom); din = W'($urandom);
    end
    btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      mode = 2'($urandom); din = W'($urandom);
    end
    check_eq("churn_one_commit", 32'(n_commit - c0), 32'd1);

    // random button segments with operand churn and occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      btn = 1'($urandom_range(0, 1));
      for (int k = 0, n = $urandom_range(1, 10); k < n; k++) begin
        step();
        mode = 2'($urandom); din = W'($urandom);
      end
      if ($urandom_range(0, 15) == 0) async_reset();
    end
    btn = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
